// File: rtl/speicher_pkg.sv
// rtl/speicher_pkg.sv - shared state encoding, port IDs and fill word for the memory arbiter
package speicher_pkg;

  typedef enum logic [1:0] {
    RUHE   = 2'd0,
    INSTR  = 2'd1,
    DATEN  = 2'd2,
    FERTIG = 2'd3
  } zustand_t;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATEN = 1'b1;

  localparam logic [31:0] TIMEOUT_FUELLWORT = 32'hDEADBEEF;

endpackage

// File: rtl/speicher_rr_waehler.sv
// rtl/speicher_rr_waehler.sv - combinational two-way round-robin picker
module speicher_rr_waehler
  import speicher_pkg::*;
(
  input  logic anfrage_instr_i,
  input  logic anfrage_daten_i,
  input  logic letzter_i,
  output logic gewaehrt_o,
  output logic port_o
);

  always_comb begin
    gewaehrt_o = anfrage_instr_i | anfrage_daten_i;
    port_o     = PORT_INSTR;
    if (anfrage_instr_i && anfrage_daten_i) begin
      // On contention the port that was not served last wins.
      port_o = (letzter_i == PORT_INSTR) ? PORT_DATEN : PORT_INSTR;
    end else if (anfrage_daten_i) begin
      port_o = PORT_DATEN;
    end
  end

endmodule

// File: rtl/speicher_arbiter.sv
// rtl/speicher_arbiter.sv - shares one single-ported memory between fetch and load/store ports
// Optional watchdog with sticky Fehler flag: define SPEICHER_TIMEOUT_EN.
module speicher_arbiter
  import speicher_pkg::*;
#(
  parameter int ADRESS_BREITE  = 32,
  parameter int DATEN_BREITE   = 32,
  parameter int TIMEOUT_ZYKLEN = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     LeseInstruktion,
  input  logic [ADRESS_BREITE-1:0] InstruktionAdresse,
  output logic [DATEN_BREITE-1:0]  Instruktion,
  output logic                     InstruktionGeladen,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  input  logic [ADRESS_BREITE-1:0] DatenAdresse,
  input  logic [DATEN_BREITE-1:0]  DatenRaus,
  output logic [DATEN_BREITE-1:0]  DatenRein,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic                     SpeicherAnfrage,
  output logic                     SpeicherSchreiben,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [DATEN_BREITE-1:0]  SpeicherDatenRaus,
  input  logic [DATEN_BREITE-1:0]  SpeicherDatenRein,
  input  logic                     SpeicherBereit,
  output logic                     Fehler
);

  zustand_t                 zustand_q, zustand_d;
  logic                     letzter_q, letzter_d;
  logic                     port_q, port_d;
  logic                     schreib_q, schreib_d;
  logic [ADRESS_BREITE-1:0] adresse_q, adresse_d;
  logic [DATEN_BREITE-1:0]  wdaten_q, wdaten_d;
  logic [DATEN_BREITE-1:0]  instr_q, instr_d;
  logic [DATEN_BREITE-1:0]  rdaten_q, rdaten_d;

  logic gewaehrt;
  logic gewaehrt_port;

`ifdef SPEICHER_TIMEOUT_EN
  logic [15:0] zaehler_q, zaehler_d;
  logic        fehler_q, fehler_d;
`endif

  speicher_rr_waehler u_waehler (
    .anfrage_instr_i (LeseInstruktion),
    .anfrage_daten_i (LeseDaten | SchreibeDaten),
    .letzter_i       (letzter_q),
    .gewaehrt_o      (gewaehrt),
    .port_o          (gewaehrt_port)
  );

  always_comb begin
    zustand_d = zustand_q;
    letzter_d = letzter_q;
    port_d    = port_q;
    schreib_d = schreib_q;
    adresse_d = adresse_q;
    wdaten_d  = wdaten_q;
    instr_d   = instr_q;
    rdaten_d  = rdaten_q;
`ifdef SPEICHER_TIMEOUT_EN
    zaehler_d = zaehler_q;
    fehler_d  = fehler_q;
`endif

    unique case (zustand_q)
      RUHE: begin
        if (gewaehrt) begin
          port_d = gewaehrt_port;
`ifdef SPEICHER_TIMEOUT_EN
          zaehler_d = '0;
`endif
          if (gewaehrt_port == PORT_INSTR) begin
            adresse_d = InstruktionAdresse;
            schreib_d = 1'b0;
            zustand_d = INSTR;
          end else begin
            // A simultaneous read and write request is served as a write.
            adresse_d = DatenAdresse;
            schreib_d = SchreibeDaten;
            wdaten_d  = DatenRaus;
            zustand_d = DATEN;
          end
        end
      end

      INSTR, DATEN: begin
        if (SpeicherBereit) begin
          if (!schreib_q) begin
            if (port_q == PORT_INSTR) instr_d  = SpeicherDatenRein;
            else                      rdaten_d = SpeicherDatenRein;
          end
          letzter_d = port_q;
          zustand_d = FERTIG;
        end
`ifdef SPEICHER_TIMEOUT_EN
        else if (zaehler_q == 16'(TIMEOUT_ZYKLEN - 1)) begin
          if (!schreib_q) begin
            if (port_q == PORT_INSTR) instr_d  = DATEN_BREITE'(TIMEOUT_FUELLWORT);
            else                      rdaten_d = DATEN_BREITE'(TIMEOUT_FUELLWORT);
          end
          fehler_d  = 1'b1;
          letzter_d = port_q;
          zustand_d = FERTIG;
        end else begin
          zaehler_d = zaehler_q + 16'd1;
        end
`endif
      end

      FERTIG: zustand_d = RUHE;

      default: zustand_d = RUHE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zustand_q <= RUHE;
      letzter_q <= PORT_INSTR;
      port_q    <= PORT_INSTR;
      schreib_q <= 1'b0;
      adresse_q <= '0;
      wdaten_q  <= '0;
      instr_q   <= '0;
      rdaten_q  <= '0;
    end else begin
      zustand_q <= zustand_d;
      letzter_q <= letzter_d;
      port_q    <= port_d;
      schreib_q <= schreib_d;
      adresse_q <= adresse_d;
      wdaten_q  <= wdaten_d;
      instr_q   <= instr_d;
      rdaten_q  <= rdaten_d;
    end
  end

`ifdef SPEICHER_TIMEOUT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      zaehler_q <= '0;
      fehler_q  <= 1'b0;
    end else begin
      zaehler_q <= zaehler_d;
      fehler_q  <= fehler_d;
    end
  end
  assign Fehler = fehler_q;
`else
  assign Fehler = 1'b0;
`endif

  assign SpeicherAnfrage    = (zustand_q == INSTR) || (zustand_q == DATEN);
  assign SpeicherSchreiben  = schreib_q;
  assign SpeicherAdresse    = adresse_q;
  assign SpeicherDatenRaus  = wdaten_q;
  assign Instruktion        = instr_q;
  assign DatenRein          = rdaten_q;
  assign InstruktionGeladen = (zustand_q == FERTIG) && (port_q == PORT_INSTR);
  assign DatenGeladen       = (zustand_q == FERTIG) && (port_q == PORT_DATEN) && !schreib_q;
  assign DatenGespeichert   = (zustand_q == FERTIG) && (port_q == PORT_DATEN) && schreib_q;

endmodule

// File: doc/speicher_arbiter.md
Name: speicher_arbiter

Overview:
- Shares one single-ported memory between the CPU instruction-fetch port and the CPU data load/store port.
- Sits between the CPU and the memory/bus.
- Serialises requests with round-robin arbitration and returns per-port completion pulses.
- Implements the CPU-facing handshakes: LeseInstruktion/InstruktionGeladen, LeseDaten/DatenGeladen and SchreibeDaten/DatenGespeichert.

Parameters:
- ADRESS_BREITE, 32, width of all addresses.
- DATEN_BREITE, 32, width of all data words.
- TIMEOUT_ZYKLEN, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LeseInstruktion  in  1  instruction-read request (level).
- InstruktionAdresse  in  ADRESS_BREITE  fetch address.
- Instruktion  out  DATEN_BREITE  fetched word; valid while InstruktionGeladen=1.
- InstruktionGeladen  out  1  one-cycle fetch-done pulse.
- LeseDaten  in  1  data-read request (level).
- SchreibeDaten  in  1  data-write request (level).
- DatenAdresse  in  ADRESS_BREITE  data address.
- DatenRaus  in  DATEN_BREITE  write data from the CPU.
- DatenRein  out  DATEN_BREITE  load result; valid while DatenGeladen=1.
- DatenGeladen  out  1  one-cycle load-done pulse.
- DatenGespeichert  out  1  one-cycle store-done pulse.
- SpeicherAnfrage  out  1  memory request, held until SpeicherBereit.
- SpeicherSchreiben  out  1  1 = write, 0 = read; stable while SpeicherAnfrage=1.
- SpeicherAdresse  out  ADRESS_BREITE  memory address; stable while SpeicherAnfrage=1.
- SpeicherDatenRaus  out  DATEN_BREITE  memory write data.
- SpeicherDatenRein  in  DATEN_BREITE  memory read data; valid while SpeicherBereit=1.
- SpeicherBereit  in  1  memory completion; single-cycle pulse.
- Fehler  out  1  sticky error flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=RUHE, letzter=INSTR.
  - All outputs 0; Instruktion and DatenRein are 0.
- Reset mid-transaction: the memory transaction is abandoned, SpeicherAnfrage drops immediately, and no done pulse is issued.
- States:
  - RUHE: idle, sampling requests.
  - INSTR: fetch in flight.
  - DATEN: load or store in flight.
  - FERTIG: one cycle; the done pulse is high.
- RUHE:
  - Only the instruction port requesting: go to INSTR.
  - Only the data port requesting: go to DATEN.
  - Both requesting: grant the port not equal to letzter (round-robin).
  - On the transition edge, latch address, write data and direction into registers; SpeicherAnfrage=1 from the next cycle.
  - Request-to-SpeicherAnfrage latency: 1 cycle.
- INSTR/DATEN:
  - SpeicherAnfrage, SpeicherSchreiben, SpeicherAdresse and SpeicherDatenRaus are held from registers and do not follow CPU inputs.
  - On SpeicherBereit=1: capture SpeicherDatenRein on a read, update letzter, go to FERTIG.
- FERTIG:
  - Exactly one of InstruktionGeladen, DatenGeladen or DatenGespeichert is high for 1 cycle, with data presented on the matching output.
  - Next state RUHE.
  - SpeicherBereit-to-done latency: 1 cycle.
- Requester obligation: drop the request by the cycle after the done pulse. The arbiter does not re-sample in FERTIG, so no duplicate grant occurs.
- Minimum transaction: 3 cycles (RUHE, busy with Bereit in the first cycle, FERTIG).
- LeseDaten and SchreibeDaten both high: treated as a write; the read is ignored.
- SpeicherBereit while in RUHE or FERTIG: ignored.
- A request dropped while granted: the transaction completes anyway and the done pulse is still issued.
- Instruktion and DatenRein hold their last value after the pulse; they are only updated on a completion.

Optional Feature:
- Macro: SPEICHER_TIMEOUT_EN.
- When defined:
  - An 8..16-bit counter clears on entry to INSTR/DATEN and counts each busy cycle.
  - When it reaches TIMEOUT_ZYKLEN without SpeicherBereit: SpeicherAnfrage drops, the read result is 32'hDEADBEEF, the done pulse is issued as normal via FERTIG, and Fehler is set.
  - Fehler is sticky until reset.
- When undefined: no counter, Fehler=0, and the arbiter waits indefinitely.

Decomposition:
- Shared package speicher_pkg holds:
  - state encoding constants: RUHE=2'd0, INSTR=2'd1, DATEN=2'd2, FERTIG=2'd3;
  - port-ID constants PORT_INSTR and PORT_DATEN;
  - the timeout fill word 32'hDEADBEEF.
- One natural sub-module, speicher_rr_waehler: combinational two-way round-robin picker (requests, letzter → grant).
- Everything else stays in speicher_arbiter.

Test Plan:
- Fetch only, address 0x10, memory returns 0x12345678 after 2 wait cycles → SpeicherAnfrage high 3 cycles, then InstruktionGeladen one cycle with Instruktion=0x12345678; DatenGeladen and DatenGespeichert stay 0.
- Store 0xCAFEBABE to 0x200 → SpeicherSchreiben=1, SpeicherAdresse=0x200, SpeicherDatenRaus=0xCAFEBABE stable until Bereit; DatenGespeichert pulses once.
- Fetch and load raised together right after reset → data granted first (letzter=INSTR); fetch granted in the next RUHE; exactly one pulse each, in that order.
- CPU changes DatenAdresse from 0x40 to 0x80 mid-load → SpeicherAdresse stays 0x40 until completion.
- Reset pulled low while in DATEN → SpeicherAnfrage and all outputs 0 immediately (asynchronously); after release, state RUHE and no stale pulse.
- With SPEICHER_TIMEOUT_EN, TIMEOUT_ZYKLEN=4, memory never responds → SpeicherAnfrage drops after 4 cycles; DatenGeladen pulses with DatenRein=0xDEADBEEF; Fehler=1 and stays 1.
